// File: rtl/seq_store.sv
// seq_store: DEPTH-entry word store between the input FSM and the seven-segment driver.
// Optional feature macro SEQ_STORE_OVERWRITE_EN: a full store overwrites its oldest entry instead of dropping.
module seq_store #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 10,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_valid,
  input  logic [1:0]       wr_err,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             clr,
  input  logic             nxt,
  output logic [WIDTH-1:0] rd_data,
  output logic [IDX_W-1:0] rd_idx,
  output logic [IDX_W-1:0] count,
  output logic             empty,
  output logic             full,
  output logic [1:0]       err_out,
  output logic             ovf
);

  localparam logic [IDX_W-1:0] DEPTH_I = IDX_W'(DEPTH);
  localparam logic [IDX_W:0]   DEPTH_X = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] ONE     = IDX_W'(1);

  // (a + b) mod DEPTH for a < DEPTH and b <= DEPTH; one conditional subtract is enough.
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] a,
                                                 input logic [IDX_W-1:0] b);
    logic [IDX_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= DEPTH_X) s = s - DEPTH_X;
    return s[IDX_W-1:0];
  endfunction

  function automatic logic [IDX_W-1:0] cursor_step(input logic [IDX_W-1:0] idx,
                                                    input logic [IDX_W-1:0] cnt);
    if (cnt == '0)        return '0;
    if (idx == cnt - ONE) return '0;
    return idx + ONE;
  endfunction

  logic [WIDTH-1:0] mem [DEPTH];
  logic [IDX_W-1:0] head;
  logic             good_wr_p0;
  logic             bad_wr_p0;
  logic [IDX_W-1:0] wr_addr_p0;
  logic [IDX_W-1:0] rd_addr_p0;
  logic [IDX_W-1:0] rd_idx_nxt_p0;

  assign empty = (count == '0);
  assign full  = (count == DEPTH_I);

  // Cursor decisions use the pre-write count so a same-cycle write never changes the wrap point.
  always_comb begin
    good_wr_p0    = wr_valid && (wr_err == 2'b00);
    bad_wr_p0     = wr_valid && (wr_err != 2'b00);
    wr_addr_p0    = wrap_add(head, count);
    rd_addr_p0    = wrap_add(head, rd_idx);
    rd_idx_nxt_p0 = nxt ? cursor_step(rd_idx, count) : rd_idx;
  end

  // p0 -> p1: store/cursor update and registered read of the pre-update state
  always_ff @(posedge clk) begin
    if (!reset_n || clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      head    <= '0;
      count   <= '0;
      rd_idx  <= '0;
      rd_data <= '0;
      err_out <= 2'b00;
      ovf     <= 1'b0;
    end else begin
      rd_data <= empty ? '0 : mem[rd_addr_p0];
      rd_idx  <= rd_idx_nxt_p0;
      if (bad_wr_p0) err_out <= wr_err;
      if (good_wr_p0) begin
        if (!full) begin
          mem[wr_addr_p0] <= wr_data;
          count           <= count + ONE;
        end else begin
`ifdef SEQ_STORE_OVERWRITE_EN
          mem[head] <= wr_data;
          head      <= wrap_add(head, ONE);
`else
          ovf <= 1'b1;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_store.sv
// tb_seq_store: directed scenarios plus random traffic against a queue-based reference model.
module tb_seq_store;
  localparam int WIDTH = 32;
  localparam int DEPTH = 10;
  localparam int IDX_W = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             wr_valid;
  logic [1:0]       wr_err;
  logic [WIDTH-1:0] wr_data;
  logic             clr;
  logic             nxt;
  logic [WIDTH-1:0] rd_data;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] count;
  logic             empty;
  logic             full;
  logic [1:0]       err_out;
  logic             ovf;

  seq_store #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset_n(reset_n), .wr_valid(wr_valid), .wr_err(wr_err),
    .wr_data(wr_data), .clr(clr), .nxt(nxt), .rd_data(rd_data), .rd_idx(rd_idx),
    .count(count), .empty(empty), .full(full), .err_out(err_out), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: a queue holding entries oldest-first, plus cursor and sticky flags.
  logic [WIDTH-1:0] q[$];
  int               m_idx = 0;
  logic [1:0]       m_err = 2'b00;
  logic             m_ovf = 1'b0;
  logic [WIDTH-1:0] m_rd  = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic rn, input logic wv, input logic [1:0] we,
                       input logic [WIDTH-1:0] wd, input logic c, input logic n);
    int pre;
    reset_n = rn; wr_valid = wv; wr_err = we; wr_data = wd; clr = c; nxt = n;
    @(posedge clk);
    if (!rn || c) begin
      q.delete();
      m_idx = 0; m_err = 2'b00; m_ovf = 1'b0; m_rd = '0;
    end else begin
      pre  = q.size();
      m_rd = (pre == 0) ? '0 : q[m_idx];
      if (n) m_idx = (pre == 0 || m_idx == pre - 1) ? 0 : m_idx + 1;
      if (wv) begin
        if (we != 2'b00) m_err = we;
        else if (pre < DEPTH) q.push_back(wd);
        else begin
`ifdef SEQ_STORE_OVERWRITE_EN
          void'(q.pop_front());
          q.push_back(wd);
`else
          m_ovf = 1'b1;
`endif
        end
      end
    end
    #1;
    check("rd_data", rd_data, m_rd);
    check("rd_idx",  rd_idx,  m_idx);
    check("count",   count,   q.size());
    check("empty",   empty,   q.size() == 0);
    check("full",    full,    q.size() == DEPTH);
    check("err_out", err_out, m_err);
    check("ovf",     ovf,     m_ovf);
  endtask

  task automatic idle();                          cycle(1, 0, 2'b00, '0, 0, 0); endtask
  task automatic wr(input logic [WIDTH-1:0] d);   cycle(1, 1, 2'b00, d,  0, 0); endtask
  task automatic step();                          cycle(1, 0, 2'b00, '0, 0, 1); endtask
  task automatic rst();                           cycle(0, 0, 2'b00, '0, 0, 0); endtask

  initial begin
    reset_n = 1'b0; wr_valid = 1'b0; wr_err = 2'b00; wr_data = '0; clr = 1'b0; nxt = 1'b0;

    // Scenario 1: three writes then cursor walk with wrap
    rst(); rst();
    check("t1_reset_count", count, 0);
    check("t1_reset_rd", rd_data, 0);
    wr(32'h11); wr(32'h22); wr(32'h33);
    check("t1_count", count, 3);
    check("t1_rd0", rd_data, 32'h11);
    step(); idle(); check("t1_rd1", rd_data, 32'h22);
    step(); idle(); check("t1_rd2", rd_data, 32'h33);
    step(); idle(); check("t1_wrap", rd_data, 32'h11);

    // Scenario 2: error words are latched but not stored
    cycle(1, 1, 2'b10, 32'hAA, 0, 0);
    check("t2_err", err_out, 2);
    check("t2_count", count, 3);
    wr(32'h44);
    check("t2_err_sticky", err_out, 2);
    check("t2_count4", count, 4);

    // Scenario 3: overfill
    rst();
    for (int i = 1; i <= 11; i++) wr(i);
    check("t3_count", count, DEPTH);
    idle();
`ifdef SEQ_STORE_OVERWRITE_EN
    check("t3_ovf", ovf, 0);
    check("t3_rd_oldest", rd_data, 2);
`else
    check("t3_ovf", ovf, 1);
    check("t3_rd_oldest", rd_data, 1);
`endif
    for (int i = 0; i < 9; i++) step();
    idle();
`ifdef SEQ_STORE_OVERWRITE_EN
    check("t3_entry9", rd_data, 11);
`else
    check("t3_entry9", rd_data, 10);
`endif

    // Scenario 4: simultaneous write and cursor wrap
    rst();
    wr(32'h10); wr(32'h20); step();
    check("t4_idx_pre", rd_idx, 1);
    cycle(1, 1, 2'b00, 32'h55, 0, 1);
    check("t4_idx", rd_idx, 0);
    check("t4_count", count, 3);

    // Scenario 5: soft clear, then cursor on empty store
    rst();
    for (int i = 1; i <= 5; i++) wr(i);
    step(); step(); step();
    cycle(1, 1, 2'b01, 32'hEE, 0, 0);
    check("t5_pre_idx", rd_idx, 3);
    check("t5_pre_err", err_out, 1);
    cycle(1, 0, 2'b00, '0, 1, 0);
    check("t5_clr_count", count, 0);
    check("t5_clr_err", err_out, 0);
    check("t5_clr_rd", rd_data, 0);
    step();
    check("t5_empty_idx", rd_idx, 0);

    // Scenario 6: reset wins over a same-cycle write and cursor step
    wr(32'h66); wr(32'h67); step();
    cycle(0, 1, 2'b00, 32'h77, 0, 1);
    check("t6_count", count, 0);
    check("t6_idx", rd_idx, 0);
    check("t6_empty", empty, 1);
    idle();
    check("t6_rd", rd_data, 0);

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      cycle(($urandom_range(99) != 0),
            ($urandom_range(1) == 1),
            ($urandom_range(3) == 0) ? 2'($urandom_range(3)) : 2'b00,
            $urandom(),
            ($urandom_range(49) == 0),
            ($urandom_range(9) < 4));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
